// File: rtl/us_ranging_scheduler_pkg.sv
// Shared types and default timing for the ultrasonic ranging scheduler.
package us_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  localparam int CLK_HZ           = 50_000_000;
  localparam int DEF_N_SENSORS    = 3;
  localparam int DEF_TRIG_CYCLES  = 500;        // 10 us
  localparam int DEF_ECHO_TIMEOUT = 1_250_000;  // 25 ms
  localparam int DEF_GAP_CYCLES   = 3_000_000;  // 60 ms
  localparam int DEF_OBST_THRESH  = 20_000;

endpackage

// File: rtl/us_ranging_scheduler_if.sv
// Control, sensor and result signals of the ranging scheduler.
// master = controlling side (drives enable/mask, sees results), slave = scheduler.
interface us_ranging_scheduler_if
  import us_pkg::*;
#(
  parameter int N_SENSORS = DEF_N_SENSORS
);
  localparam int ID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  logic                 enable;
  logic [N_SENSORS-1:0] sensor_mask;
  logic [N_SENSORS-1:0] echo_rx;
  logic [N_SENSORS-1:0] trigger;
  logic                 busy;
  logic                 sample_valid;
  logic [ID_W-1:0]      sample_id;
  logic [31:0]          sample_duration;
  logic                 sample_timeout;
  logic [N_SENSORS-1:0] fault;

  modport master (
    output enable, sensor_mask, echo_rx,
    input  trigger, busy, sample_valid, sample_id, sample_duration,
           sample_timeout, fault
  );

  modport slave (
    input  enable, sensor_mask, echo_rx,
    output trigger, busy, sample_valid, sample_id, sample_duration,
           sample_timeout, fault
  );

endinterface

// File: rtl/us_ranging_scheduler_rr_pick.sv
// Round-robin pick: first set mask bit strictly after last_id, wrapping.
// last_id itself is considered last, so a single enabled sensor repeats.
module us_rr_pick #(
  parameter int N    = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] last_id,
  output logic [ID_W-1:0] next_id,
  output logic            found
);

  // scan from farthest to nearest so the nearest candidate wins
  always_comb begin
    int idx;
    found   = 1'b0;
    next_id = '0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_id) + k) % N;
      if (mask[idx]) begin
        found   = 1'b1;
        next_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/us_ranging_scheduler.sv
// Shares one ranging engine across N ultrasonic sensors: trigger, time the
// echo-high width with timeout, then hold off for a gap before the next shot.
module us_ranging_scheduler
  import us_pkg::*;
#(
  parameter int N_SENSORS    = DEF_N_SENSORS,
  parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
  parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int OBST_THRESH  = DEF_OBST_THRESH
) (
  input logic                  clk_50M,
  input logic                  reset,
  us_ranging_scheduler_if.slave bus
);

  localparam int ID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(ECHO_TIMEOUT - 1);
  localparam logic [31:0] TO_VAL    = 32'(ECHO_TIMEOUT);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] OBST_VAL  = 32'(OBST_THRESH);

  state_t               state, state_nxt;
  logic [31:0]          cnt, cnt_nxt;
  logic [ID_W-1:0]      cur_id, last_id, next_id;
  logic                 found;
  logic [N_SENSORS-1:0] echo_m, echo_s;
  logic                 echo_sel;
  logic                 pub, pub_to;
  logic                 start;

  logic                 smp_valid, smp_to;
  logic [ID_W-1:0]      smp_id;
  logic [31:0]          smp_dur;
  logic [N_SENSORS-1:0] fault_q;

  us_rr_pick #(.N(N_SENSORS), .ID_W(ID_W)) u_pick (
    .mask    (bus.sensor_mask),
    .last_id (last_id),
    .next_id (next_id),
    .found   (found)
  );

  // two-flop synchroniser on every echo line
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= bus.echo_rx;
      echo_s <= echo_m;
    end
  end

  assign echo_sel = echo_s[cur_id];
  assign start    = (state == IDLE) && bus.enable && found;

  // state and shared counter registers
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next-state, counter and publish decode; counter always restarts on exit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pub       = 1'b0;
    pub_to    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = TRIG;
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_nxt = WAIT_RISE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 32'd1;
      end
      WAIT_RISE: begin
        if (echo_sel) begin
          state_nxt = MEASURE;
          cnt_nxt   = 32'd1;
        end else if (cnt == TO_LAST) begin
          pub       = 1'b1;
          pub_to    = 1'b1;
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 32'd1;
      end
      MEASURE: begin
        if (!echo_sel) begin
          pub       = 1'b1;
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (cnt == TO_VAL) begin
          pub       = 1'b1;
          pub_to    = 1'b1;
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 32'd1;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + 32'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // sensor selection, result registers and per-sensor obstacle flags
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      cur_id    <= '0;
      last_id   <= ID_W'(N_SENSORS - 1);
      smp_valid <= 1'b0;
      smp_id    <= '0;
      smp_dur   <= '0;
      smp_to    <= 1'b0;
      fault_q   <= '0;
    end else begin
      if (start) cur_id <= next_id;
      smp_valid <= pub;
      if (pub) begin
        smp_id          <= cur_id;
        smp_dur         <= pub_to ? TO_VAL : cnt;
        smp_to          <= pub_to;
        last_id         <= cur_id;
        fault_q[cur_id] <= !pub_to && (cnt < OBST_VAL);
      end
    end
  end

  // one-hot trigger decoded from registered state
  always_comb begin
    bus.trigger = '0;
    if (state == TRIG) bus.trigger[cur_id] = 1'b1;
  end

  assign bus.busy            = (state != IDLE);
  assign bus.sample_valid    = smp_valid;
  assign bus.sample_id       = smp_id;
  assign bus.sample_duration = smp_dur;
  assign bus.sample_timeout  = smp_to;
  assign bus.fault           = fault_q;

endmodule
